// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Groups the bus signals of mem_arbiter: the fetch port (if_*), the data
// port (d_*) and the single-ported memory bus (mem_*).
//   master : arbiter side - takes requests, drives grants/responses and the
//            memory request bus, takes memory ready/response.
//   slave  : environment side (fetch, memory stage and memory model).
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    // memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory bus between instruction fetch and the
// data (load/store) stage. One transaction in flight at a time. Data wins
// arbitration unless fetch has been passed over STARVE_LIMIT times in a row.
// All outputs are registered.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter_if.master: fetch port, data port and memory bus
// Parameters:
//   STARVE_LIMIT - data grants allowed while fetch waits (1..15)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;        // 1 = data owns the bus
    logic [3:0]  starve_q, starve_d;

    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        grant_d;
    logic        grant_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        grant_d     = 1'b0;
        grant_f     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.d_req && ((starve_q < LIMIT) || !bus.if_req)) begin
                    grant_d     = 1'b1;
                    owner_d     = 1'b1;
                    d_gnt_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                    state_d     = REQ;
                end else if (bus.if_req) begin
                    grant_f     = 1'b1;
                    owner_d     = 1'b0;
                    if_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // mem_rvalid is deliberately not looked at here
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.mem_rvalid) begin
                    if (owner_q) begin
                        d_rdata_d  = bus.mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus.mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation counter: only counts data wins that made fetch wait.
        if (!bus.if_req || grant_f) begin
            starve_d = '0;
        end else if (grant_d && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Inputs are driven 1 time unit after the
// rising edge and outputs are observed at the same point, so the values seen
// after edge n are the registered results of the inputs driven in cycle n-1.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " if_gnt"},    32'(bus.if_gnt), 32'd0);
        check({tag, " d_gnt"},     32'(bus.d_gnt), 32'd0);
        check({tag, " if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        check({tag, " d_rvalid"},  32'(bus.d_rvalid), 32'd0);
        check({tag, " if_rdata"},  bus.if_rdata, 32'd0);
        check({tag, " d_rdata"},   bus.d_rdata, 32'd0);
        check({tag, " mem_req"},   32'(bus.mem_req), 32'd0);
        check({tag, " mem_we"},    32'(bus.mem_we), 32'd0);
        check({tag, " mem_addr"},  bus.mem_addr, 32'd0);
        check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, " mem_be"},    32'(bus.mem_be), 32'd0);
    endtask

    // Watchdog: the directed sequence is short; anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] order;
        logic       is_d;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // ---------------- reset values ----------------
        step(); step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // ---------------- single fetch ----------------
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();                                     // cycle 1
        check("fetch if_gnt",   32'(bus.if_gnt), 32'd1);
        check("fetch d_gnt",    32'(bus.d_gnt), 32'd0);
        check("fetch mem_req",  32'(bus.mem_req), 32'd1);
        check("fetch mem_addr", bus.mem_addr, 32'h100);
        check("fetch mem_be",   32'(bus.mem_be), 32'hF);
        check("fetch mem_we",   32'(bus.mem_we), 32'd0);
        bus.if_req = 1'b0; bus.mem_ready = 1'b1;
        step();                                     // cycle 2
        check("fetch gnt pulse", 32'(bus.if_gnt), 32'd0);
        check("fetch mem_req drop", 32'(bus.mem_req), 32'd0);
        check("fetch early rvalid", 32'(bus.if_rvalid), 32'd0);
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00500113;
        step();                                     // cycle 3
        check("fetch if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("fetch if_rdata",  bus.if_rdata, 32'h00500113);
        check("fetch d_rvalid",  32'(bus.d_rvalid), 32'd0);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step();
        check("fetch rvalid pulse", 32'(bus.if_rvalid), 32'd0);

        // ---------------- store with wait states ----------------
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd100;
        bus.d_wdata = 32'd25; bus.d_be = 4'hF;
        step();                                     // cycle 1
        check("store d_gnt",     32'(bus.d_gnt), 32'd1);
        check("store mem_req c1", 32'(bus.mem_req), 32'd1);
        check("store mem_we",    32'(bus.mem_we), 32'd1);
        check("store mem_addr",  bus.mem_addr, 32'd100);
        check("store mem_wdata", bus.mem_wdata, 32'd25);
        check("store mem_be",    32'(bus.mem_be), 32'hF);
        // d_req still held during the grant cycle
        step();                                     // cycle 2
        check("store no reissue", 32'(bus.d_gnt), 32'd0);
        check("store mem_req c2", 32'(bus.mem_req), 32'd1);
        bus.d_req = 1'b0;
        bus.mem_rvalid = 1'b1;                      // response during REQ is ignored
        step();                                     // cycle 3
        check("store mem_req c3",  32'(bus.mem_req), 32'd1);
        check("store rvalid in REQ", 32'(bus.d_rvalid), 32'd0);
        bus.mem_rvalid = 1'b0;
        step();                                     // cycle 4
        check("store mem_req c4",  32'(bus.mem_req), 32'd1);
        check("store addr stable", bus.mem_addr, 32'd100);
        check("store data stable", bus.mem_wdata, 32'd25);
        bus.mem_ready = 1'b1;
        step();                                     // cycle 5 (RESP)
        check("store mem_req c5", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;
        step();                                     // cycle 6
        check("store rvalid early", 32'(bus.d_rvalid), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();                                     // cycle 7
        check("store d_rvalid",  32'(bus.d_rvalid), 32'd1);
        check("store if_rvalid", 32'(bus.if_rvalid), 32'd0);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step();                                     // cycle 8
        check("store rvalid once", 32'(bus.d_rvalid), 32'd0);
        check("store no late gnt", 32'(bus.d_gnt), 32'd0);

        // ---------------- stray response in IDLE ----------------
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555AAAA;
        step();
        check("stray if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("stray d_rvalid",  32'(bus.d_rvalid), 32'd0);
        check("stray mem_req",   32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step();

        // ---------------- contention, STARVE_LIMIT=4 ----------------
        order = 10'b1111011110;                     // 1 = data grant expected
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_be = 4'h3;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            is_d = order[9 - i];
            step();
            check($sformatf("cont d_gnt %0d", i),  32'(bus.d_gnt), 32'(is_d));
            check($sformatf("cont if_gnt %0d", i), 32'(bus.if_gnt), 32'(!is_d));
            check($sformatf("cont addr %0d", i), bus.mem_addr, is_d ? 32'h80 : 32'h300);
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(i + 32'h1000);
            step();
            check($sformatf("cont d_rvalid %0d", i),  32'(bus.d_rvalid), 32'(is_d));
            check($sformatf("cont if_rvalid %0d", i), 32'(bus.if_rvalid), 32'(!is_d));
            check($sformatf("cont rdata %0d", i),
                  is_d ? bus.d_rdata : bus.if_rdata, 32'(i + 32'h1000));
            bus.mem_rvalid = 1'b0;
            if (i == 9) begin
                bus.d_req = 1'b0; bus.if_req = 1'b0;
            end
        end
        step();
        check("cont idle after", 32'(bus.mem_req), 32'd0);

        // ---------------- reset during RESP ----------------
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        step();
        check("rst fetch gnt", 32'(bus.if_gnt), 32'd1);
        bus.if_req = 1'b0; bus.mem_ready = 1'b1;
        step();                                     // now in RESP
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        step();
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00001234;
        step();
        check("rst late if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("rst late d_rvalid",  32'(bus.d_rvalid), 32'd0);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_be = 4'hF;
        step();
        check("rst new d_gnt",    32'(bus.d_gnt), 32'd1);
        check("rst new mem_addr", bus.mem_addr, 32'h40);
        bus.d_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
